counter_pair_capture: RTL and testbench
=======================================

Name: counter_pair_capture

Overview:
- Downstream consumer of the dual-counter wrapper. Samples its two count outputs (q0, q1) on a capture strobe.
- Computes the signed difference between the two counts and flags divergence beyond a limit.
- Buffers records in a small show-ahead FIFO drained over a valid/ready port, so a logger or bus bridge can read counter history without stalling the counters.

Parameters:
- WIDTH, 32, width of each incoming counter value
- DEPTH, 8, FIFO entries; power of two, >= 2
- DIFF_LIMIT, 4, unsigned magnitude; a |q0 - q1| value strictly greater than this sets the record's flag
- DROP_W, 16, width of the saturating dropped-record counter

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- cap_en  in  1  capture strobe; sample q0/q1 this cycle
- q0  in  WIDTH  counter 0 value
- q1  in  WIDTH  counter 1 value
- out_valid  out  1  FIFO head record valid
- out_ready  in  1  consumer accepts head record
- out_q0  out  WIDTH  head record q0
- out_q1  out  WIDTH  head record q1
- out_diff  out  WIDTH+1  head record signed q0 - q1
- out_flag  out  1  head record divergence flag
- level  out  $clog2(DEPTH)+1  entries currently stored
- overflow  out  1  sticky: a capture was dropped
- drop_cnt  out  DROP_W  dropped captures, saturating
- clr_ovf  in  1  clears overflow and drop_cnt

Behaviour:
- Reset (synchronous, active-high) values:
  - out_valid = 0, out_q0 = out_q1 = out_diff = 0, out_flag = 0
  - level = 0, overflow = 0, drop_cnt = 0
  - FIFO pointers = 0
- Reset asserted mid-operation discards all stored records on that edge. cap_en in the same cycle is ignored.
- Record formation (combinational, same cycle as cap_en):
  - diff = zero-extend(q0) - zero-extend(q1), computed in WIDTH+1 bits, two's complement.
  - mag = |diff| in WIDTH+1 bits.
  - flag = (mag > DIFF_LIMIT).
  - WIDTH = 32 with q0 = 0, q1 = 0xFFFFFFFF gives diff = -(2^32 - 1). No truncation.
- Push: cap_en = 1 and (not full, or a pop occurs in the same cycle). The record is written at that edge.
- Pop: out_valid & out_ready. The head advances at that edge.
- Show-ahead output:
  - out_* always reflect the head entry while out_valid = 1.
  - Latency is 1 cycle: a push into an empty FIFO gives out_valid = 1 on the next cycle.
  - No same-cycle bypass.
- While out_valid = 0, out_* hold their last values. Only out_valid is meaningful.
- level updates at the edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full (level == DEPTH):
  - cap_en without a simultaneous pop drops the record.
  - Overflow is set at that edge.
  - drop_cnt increments, saturating at 2^DROP_W - 1.
- Full with a simultaneous pop: the push is accepted and level stays at DEPTH.
- Empty with out_ready = 1: no effect.
- clr_ovf = 1:
  - overflow and drop_cnt are cleared at the edge.
  - If a drop happens in the same cycle, the drop wins: overflow = 1, drop_cnt = 1.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from level.
- out_valid and out_* must not depend combinationally on out_ready or cap_en.

Decomposition:
- Package counter_capture_pkg:
  - cap_rec_t packed struct {q0, q1, diff, flag}, parameterised through WIDTH-based localparams
  - DEFAULT_WIDTH, DEFAULT_DEPTH
  - function abs_diff
- Sub-module cap_fifo:
  - generic synchronous show-ahead FIFO of cap_rec_t
  - ports: push, pop, full, empty, level, head
- Top level holds record formation, drop/overflow logic and the handshake.

Test Plan:
- Reset then idle: hold reset 2 cycles, no cap_en -> out_valid = 0, level = 0, overflow = 0, drop_cnt = 0 on all cycles.
- Single capture:
  - Stimulus: cap_en pulse with q0 = 10, q1 = 7, out_ready = 0.
  - Next cycle: out_valid = 1, out_diff = +3, out_flag = 0, level = 1.
  - Then out_ready = 1 for 1 cycle: out_valid = 0, level = 0.
- Divergence and negative diff:
  - Capture q0 = 5, q1 = 12: out_diff = -7, out_flag = 1.
  - Capture q0 = 0, q1 = 0xFFFFFFFF: out_diff = -4294967295, out_flag = 1.
- Overflow:
  - 10 consecutive captures (q0 = 0..9, q1 = 0), out_ready = 0.
  - Result: level = 8, overflow = 1, drop_cnt = 2.
  - Drain reads q0 = 0..7 in order. Then pulse clr_ovf: overflow = 0, drop_cnt = 0.
- Full with simultaneous push/pop:
  - Fill to 8, then cap_en with out_ready = 1 for 3 cycles.
  - Result: level stays 8, drop_cnt = 0, output order preserved.
- Reset mid-stream: 4 entries stored, assert reset with cap_en = 1 -> next cycle out_valid = 0, level = 0, no record retained.

Source files
------------

// File: rtl/counter_capture_pkg.sv
// Shared types and helpers for the counter-pair capture path.
// Record layout, default sizing and the magnitude helper used for divergence flags.
package counter_capture_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 8;
  localparam int REC_DIFF_W    = DEFAULT_WIDTH + 1;

  // abs_diff works on a fixed wide container so any WIDTH up to MAX_WIDTH fits.
  localparam int MAX_WIDTH     = 64;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] q0;
    logic [DEFAULT_WIDTH-1:0] q1;
    logic [REC_DIFF_W-1:0]    diff;
    logic                     flag;
  } cap_rec_t;

  function automatic logic [MAX_WIDTH:0] abs_diff(input logic [MAX_WIDTH:0] d);
    logic [MAX_WIDTH:0] mag;
    mag = d[MAX_WIDTH] ? ({(MAX_WIDTH+1){1'b0}} - d) : d;
    return mag;
  endfunction

endpackage

// File: rtl/cap_fifo.sv
// Synchronous show-ahead FIFO of capture records with a registered head.
// Occupancy is tracked in a level counter; full/empty are derived from it.
module cap_fifo
  import counter_capture_pkg::*;
#(
  parameter type rec_t = cap_rec_t,
  parameter int  DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  rec_t                     wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output rec_t                     head
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  rec_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   rd_next;
  logic [LW-1:0]   level_q, level_d;
  rec_t            head_q, head_d;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    full     = (level_q == LW'(DEPTH));
    empty    = (level_q == '0);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    rd_next  = rd_ptr_q + PW'(1);
    wr_ptr_d = do_push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_next : rd_ptr_q;

    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // The head register is loaded with whatever becomes the oldest entry after this edge.
    head_d = head_q;
    if (do_push && (empty || (do_pop && level_q == LW'(1)))) begin
      head_d = wdata;
    end else if (do_pop && level_q > LW'(1)) begin
      head_d = mem_q[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign level = level_q;
  assign head  = head_q;

endmodule

// File: rtl/counter_pair_capture.sv
// Captures q0/q1 pairs with their signed difference and divergence flag into a FIFO.
// Dropped captures on a full FIFO raise a sticky overflow and a saturating drop count.
module counter_pair_capture
  import counter_capture_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DIFF_LIMIT = 4,
  parameter int DROP_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cap_en,
  input  logic [WIDTH-1:0]         q0,
  input  logic [WIDTH-1:0]         q1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_q0,
  output logic [WIDTH-1:0]         out_q1,
  output logic [WIDTH:0]           out_diff,
  output logic                     out_flag,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     clr_ovf
);

  typedef struct packed {
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic [WIDTH:0]   diff;
    logic             flag;
  } rec_t;

  rec_t                rec_in;
  rec_t                head;
  logic signed [WIDTH:0] diff_s;
  logic [MAX_WIDTH:0]  diff_ext;
  logic [MAX_WIDTH:0]  mag;
  logic                full;
  logic                empty;
  logic                pop;
  logic                drop;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  always_comb begin
    diff_s   = signed'({1'b0, q0} - {1'b0, q1});
    diff_ext = (MAX_WIDTH+1)'(diff_s);
    mag      = abs_diff(diff_ext);

    rec_in.q0   = q0;
    rec_in.q1   = q1;
    rec_in.diff = diff_s;
    rec_in.flag = (mag > (MAX_WIDTH+1)'(DIFF_LIMIT));
  end

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign drop      = cap_en & full & ~pop;

  cap_fifo #(
    .rec_t (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cap_en),
    .pop   (pop),
    .wdata (rec_in),
    .full  (full),
    .empty (empty),
    .level (level),
    .head  (head)
  );

  // A drop in the same cycle as a clear restarts the count at one.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_ovf) begin
        drop_cnt_d = DROP_W'(1);
      end else if (drop_cnt_q != {DROP_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign out_q0   = head.q0;
  assign out_q1   = head.q1;
  assign out_diff = head.diff;
  assign out_flag = head.flag;

endmodule

// File: tb/tb_counter_pair_capture.sv
// Bench for counter_pair_capture: directed steps plus random traffic against a queue model.
module tb_counter_pair_capture;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int DW = 4;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cap_en = 1'b0;
  logic [W-1:0]  q0 = '0;
  logic [W-1:0]  q1 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_q0;
  logic [W-1:0]  out_q1;
  logic [W:0]    out_diff;
  logic          out_flag;
  logic [3:0]    level;
  logic          overflow;
  logic [DW-1:0] drop_cnt;
  logic          clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  counter_pair_capture #(
    .WIDTH(W), .DEPTH(D), .DIFF_LIMIT(4), .DROP_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .cap_en(cap_en), .q0(q0), .q1(q1),
    .out_valid(out_valid), .out_ready(out_ready), .out_q0(out_q0), .out_q1(out_q1),
    .out_diff(out_diff), .out_flag(out_flag), .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned a;
    longint unsigned b;
    longint          d;
    bit              flag;
  } mrec_t;

  mrec_t mq[$];
  mrec_t m_head;
  bit    m_ovf;
  int    m_dcnt;

  function automatic mrec_t mk(input logic [W-1:0] a, input logic [W-1:0] b);
    mrec_t r;
    longint mag;
    r.a = longint'(a);
    r.b = longint'(b);
    r.d = longint'(r.a) - longint'(r.b);
    mag = (r.d < 0) ? -r.d : r.d;
    r.flag = (mag > 4);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [W:0] ed;
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("level", 64'(level), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_dcnt));
    if (mq.size() != 0) begin
      ed = m_head.d[W:0];
      chk("out_q0", 64'(out_q0), m_head.a);
      chk("out_q1", 64'(out_q1), m_head.b);
      chk("out_diff", 64'(out_diff), 64'(ed));
      chk("out_flag", 64'(out_flag), 64'(m_head.flag));
    end
  endtask

  task automatic step(input bit rst, input bit cap, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit rdy, input bit clr);
    bit pop;
    bit full;
    bit drop;
    reset = rst; cap_en = cap; q0 = a; q1 = b; out_ready = rdy; clr_ovf = clr;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_dcnt = 0;
      m_head = '{0, 0, 0, 0};
    end else begin
      pop  = (mq.size() != 0) && rdy;
      full = (mq.size() == D);
      drop = 0;
      if (pop) void'(mq.pop_front());
      if (cap) begin
        if (!full || pop) mq.push_back(mk(a, b));
        else drop = 1;
      end
      if (drop) begin
        m_ovf = 1;
        m_dcnt = clr ? 1 : ((m_dcnt < DMAX) ? m_dcnt + 1 : DMAX);
      end else if (clr) begin
        m_ovf = 0;
        m_dcnt = 0;
      end
      if (mq.size() != 0) m_head = mq[0];
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, '0, '0, rdy, 0);
  endtask

  initial begin
    // reset then idle
    step(1, 0, '0, '0, 0, 0);
    step(1, 0, '0, '0, 0, 0);
    chk("rst_q0", 64'(out_q0), 64'd0);
    chk("rst_q1", 64'(out_q1), 64'd0);
    chk("rst_diff", 64'(out_diff), 64'd0);
    chk("rst_flag", 64'(out_flag), 64'd0);
    for (int i = 0; i < 3; i++) idle(0);

    // single capture
    step(0, 1, 32'd10, 32'd7, 0, 0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_diff", 64'(out_diff), 64'd3);
    chk("single_flag", 64'(out_flag), 64'd0);
    idle(1);
    chk("single_drained", 64'(out_valid), 64'd0);

    // divergence and negative diffs
    step(0, 1, 32'd5, 32'd12, 0, 0);
    chk("neg7_diff", 64'(out_diff), 64'h1_FFFF_FFF9);
    chk("neg7_flag", 64'(out_flag), 64'd1);
    idle(1);
    step(0, 1, 32'd0, 32'hFFFF_FFFF, 0, 0);
    chk("min_diff", 64'(out_diff), 64'h1_0000_0001);
    chk("min_flag", 64'(out_flag), 64'd1);
    idle(1);
    step(0, 1, 32'd9, 32'd5, 0, 0);
    chk("lim_flag", 64'(out_flag), 64'd0);
    idle(1);
    step(0, 1, 32'd10, 32'd5, 0, 0);
    chk("lim1_flag", 64'(out_flag), 64'd1);
    idle(1);

    // overflow
    for (int i = 0; i < 10; i++) step(0, 1, W'(i), '0, 0, 0);
    chk("ovf_level", 64'(level), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 64'(out_q0), 64'(i));
      idle(1);
    end
    step(0, 0, '0, '0, 0, 1);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(0, 1, W'(100 + i), W'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, W'(200 + i), '0, 1, 0);
    chk("pp_level", 64'(level), 64'd8);
    chk("pp_drop", 64'(drop_cnt), 64'd0);
    chk("pp_head", 64'(out_q0), 64'd103);
    for (int i = 0; i < 9; i++) idle(1);

    // saturation and clear-vs-drop priority
    for (int i = 0; i < 8; i++) step(0, 1, W'(i), W'(i), 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 32'hDEAD, 32'd1, 0, 0);
    chk("sat_drop", 64'(drop_cnt), 64'(DMAX));
    step(0, 1, 32'd1, 32'd1, 0, 1);
    chk("clr_drop_win_ovf", 64'(overflow), 64'd1);
    chk("clr_drop_win_cnt", 64'(drop_cnt), 64'd1);
    step(0, 0, '0, '0, 0, 1);
    for (int i = 0; i < 9; i++) idle(1);
    idle(1);

    // reset mid-stream
    for (int i = 0; i < 4; i++) step(0, 1, W'(50 + i), '0, 0, 0);
    step(1, 1, 32'd77, 32'd1, 0, 0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_level", 64'(level), 64'd0);
    idle(0);
    idle(0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = ($urandom_range(0, 3) == 0) ? W'($urandom()) : W'($urandom_range(0, 20));
      b = ($urandom_range(0, 3) == 0) ? W'($urandom()) : W'($urandom_range(0, 20));
      step(($urandom_range(0, 99) == 0), bit'($urandom_range(0, 2) != 0), a, b,
           bit'($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
